mealy_pattern_detector: RTL and testbench
=========================================

// Module: mealy_pattern_detector
// PURPOSE
//   Parametrised Mealy serial-pattern detector; successor to the fixed 4-state detector.
//   Watches a 1-bit stream `a` sampled on enabled clock edges.
//   Asserts `y` in the same cycle that the last bit of PATTERN arrives.
//   Counts matches in a saturating counter; overlap mode is selectable.
//   Sits between the input synchroniser/strobe generator and the status/LED logic of the lab top.
// PARAMETERS
//   WIDTH    4        pattern length in bits, legal 2..16
//   PATTERN  4'b1101  reset/default pattern; bit WIDTH-1 is the earliest bit in time
//   OVERLAP  1        1: overlapping matches counted; 0: window restarts after each match
//   CNT_W    8        match counter width, legal 1..16
// PORTS
//   clock        in   1      single clock, all flops rising edge
//   reset_n      in   1      synchronous active-low reset
//   enable       in   1      sample strobe; state advances only when 1
//   a            in   1      serial input bit
//   cnt_clr      in   1      synchronous clear of match_cnt
//   y            out  1      Mealy match output, combinational from a/enable/state
//   match_cnt    out  CNT_W  saturating count of matches
//   cnt_sat      out  1      1 when match_cnt == 2**CNT_W-1
// BEHAVIOUR
//   - State registers:
//     - hist[WIDTH-2:0]: last WIDTH-1 accepted bits, newest in bit 0.
//     - fill: 0..WIDTH-1, number of valid bits in hist.
//     - pat_reg: the active pattern.
//   - Reset (reset_n==0 at an edge):
//     - hist=0, fill=0, match_cnt=0, pat_reg=PATTERN.
//     - Reset has priority over every other input.
//     - y is 0 while reset_n==0.
//   - Match condition:
//     - hit = enable & (fill==WIDTH-1) & ({hist,a}==pat_reg).
//     - y = hit & reset_n. Zero latency (Mealy), valid before the edge.
//   - Edge with enable==1:
//     - hist <= {hist[WIDTH-3:0],a}.
//     - fill <= min(fill+1, WIDTH-1).
//     - If hit and OVERLAP==0: fill <= 0 (the shifted hist contents are don't-care).
//   - Edge with enable==0: all state holds; y=0; `a` is ignored.
//   - Counter:
//     - On a hit edge: match_cnt <= match_cnt+1, saturating at 2**CNT_W-1 (never wraps).
//     - cnt_clr alone: match_cnt <= 0.
//     - cnt_clr together with hit: match_cnt <= 1.
//     - cnt_clr does not affect hist, fill or pat_reg.
//   - cnt_sat is combinational from match_cnt and is 0 after reset.
//   - WIDTH==2: hist is 1 bit; the same rules apply.
// CONFIGURATION
//   Macro MEALY_PATTERN_LOAD_EN adds runtime pattern loading.
//   - Defined:
//     - Extra ports: load (in, 1) and load_pattern (in, WIDTH).
//     - Edge with load==1: pat_reg <= load_pattern and fill <= 0.
//     - load has priority over enable: no shift and no count on that edge.
//     - y is forced to 0 while load==1.
//     - match_cnt is retained across a load.
//     - reset_n still restores pat_reg=PATTERN.
//   - Not defined:
//     - The load ports are absent.
//     - pat_reg is the constant PATTERN; no pattern flops are synthesised.
// STRUCTURE
//   - Package mealy_det_pkg:
//     - MAX_WIDTH=16, MAX_CNT_W=16.
//     - Default pattern constant DEF_PATTERN=4'b1101.
//     - Function sat_inc(cnt, en, clr).
//   - Sub-module sat_counter #(W):
//     - Inputs: clock, reset_n, inc, clr.
//     - Outputs: cnt, sat.
//     - Implements the counter rules above; instantiated once.
//   - Elaboration check: fatal error if WIDTH or CNT_W is outside its legal range.
// TESTING (WIDTH=4, PATTERN=4'b1101, CNT_W=8 unless noted; bits listed oldest first, enable=1)
//   1. Basic match:
//      - Stimulus: reset, then a=1,1,0,1.
//      - Response: y=1 only in cycle 4 (same cycle a=1); match_cnt=1 after that edge.
//   2. Overlap mode:
//      - Stimulus: a=1,1,0,1,1,0,1.
//      - OVERLAP=1: y in cycles 4 and 7, match_cnt=2.
//      - OVERLAP=0: y in cycle 4 only, match_cnt=1.
//   3. Enable gaps:
//      - Stimulus: a=1,1, then enable=0 for 3 cycles with a toggling, then a=0,1.
//      - Response: y=0 throughout the gap; y=1 on the final bit.
//   4. Saturation (CNT_W=2):
//      - Stimulus: 5 non-overlapping matches.
//      - Response: match_cnt=3 and cnt_sat=1 from the 3rd match onward.
//      - Then cnt_clr coinciding with a hit: match_cnt=1.
//   5. Reset mid-sequence:
//      - Stimulus: a=1,1,0, then reset_n=0 for one edge, then a=1.
//      - Response: no y; match_cnt=0; a fresh 1,1,0,1 then matches.
//   6. Runtime load (MEALY_PATTERN_LOAD_EN defined):
//      - Stimulus: load=1 with load_pattern=4'b0110, then stream 1,1,0,1,0,1,1,0.
//      - Response: y only on the final bit; match_cnt increments by 1 from its pre-load value.

Source files
------------

// File: rtl/mealy_det_pkg.sv
// Shared constants and counter helper for the parametrised Mealy pattern detector.
// Latency: n/a (package). Backpressure: n/a.
package mealy_det_pkg;

    localparam int MAX_WIDTH = 16;
    localparam int MAX_CNT_W = 16;

    localparam logic [3:0] DEF_PATTERN = 4'b1101;

    // Callers pad unused upper bits with ones, so "all ones" marks saturation at any width.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] cnt,
        input logic                 en,
        input logic                 clr
    );
        logic [MAX_CNT_W-1:0] res;
        res = cnt;
        if (clr) begin
            res = en ? MAX_CNT_W'(1) : '0;
        end else if (en && (cnt != '1)) begin
            res = cnt + MAX_CNT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating match counter with synchronous clear; clear together with inc yields 1.
// Latency: count visible one cycle after inc. Backpressure: none, never wraps.
module sat_counter
    import mealy_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [MAX_CNT_W-1:0] cnt_pad;

    always_comb begin
        cnt_pad        = '1;
        cnt_pad[W-1:0] = cnt;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= W'(sat_inc(cnt_pad, inc, clr));
        end
    end

    assign sat = (cnt == {W{1'b1}});

endmodule

// File: rtl/mealy_pattern_detector.sv
// Mealy serial-pattern detector with saturating match counter; MEALY_PATTERN_LOAD_EN adds runtime pattern load.
// Latency: y is combinational in the cycle the last bit arrives. Backpressure: enable gates sampling only.
module mealy_pattern_detector
    import mealy_det_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEF_PATTERN),
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             a,
    input  logic             cnt_clr,
`ifdef MEALY_PATTERN_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_pattern,
`endif
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "mealy_pattern_detector: WIDTH out of range 2..16");
    end
    if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
        $fatal(1, "mealy_pattern_detector: CNT_W out of range 1..16");
    end

    localparam int               FILL_W   = $clog2(WIDTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH - 1);

    logic [WIDTH-2:0]  hist, hist_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic [WIDTH-1:0]  pat_reg;
    logic [WIDTH-1:0]  window;
    logic              load_act;
    logic              hit;

`ifdef MEALY_PATTERN_LOAD_EN
    assign load_act = load;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pat_reg <= PATTERN;
        end else if (load) begin
            pat_reg <= load_pattern;
        end
    end
`else
    assign load_act = 1'b0;
    assign pat_reg  = PATTERN;
`endif

    always_comb begin
        window   = {hist, a};
        hit      = enable & ~load_act & (fill == FILL_MAX) & (window == pat_reg);
        hist_nxt = hist;
        fill_nxt = fill;
        if (load_act) begin
            fill_nxt = '0;
        end else if (enable) begin
            hist_nxt = window[WIDTH-2:0];
            // Non-overlap mode restarts the window; stale hist bits are masked by fill.
            if (hit && OVERLAP == 0) begin
                fill_nxt = '0;
            end else if (fill != FILL_MAX) begin
                fill_nxt = fill + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hist <= '0;
            fill <= '0;
        end else begin
            hist <= hist_nxt;
            fill <= fill_nxt;
        end
    end

    assign y = hit & reset_n;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (hit),
        .clr     (cnt_clr),
        .cnt     (match_cnt),
        .sat     (cnt_sat)
    );

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// Scoreboard bench: two detectors (overlap/CNT_W=8 and non-overlap/CNT_W=2) fed the same directed stream.
// Define MEALY_PATTERN_LOAD_EN to also exercise runtime pattern loading.
module tb_mealy_pattern_detector;

    logic       clk = 1'b0;
    logic       reset_n, enable, a, cnt_clr;
    logic       y0, y1, sat0, sat1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
`ifdef MEALY_PATTERN_LOAD_EN
    logic       load;
    logic [3:0] load_pattern;
`endif

    always #5 clk = ~clk;

    mealy_pattern_detector #(.WIDTH(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) dut0 (
        .clock(clk), .reset_n(reset_n), .enable(enable), .a(a), .cnt_clr(cnt_clr),
`ifdef MEALY_PATTERN_LOAD_EN
        .load(load), .load_pattern(load_pattern),
`endif
        .y(y0), .match_cnt(cnt0), .cnt_sat(sat0)
    );

    mealy_pattern_detector #(.WIDTH(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(2)) dut1 (
        .clock(clk), .reset_n(reset_n), .enable(enable), .a(a), .cnt_clr(cnt_clr),
`ifdef MEALY_PATTERN_LOAD_EN
        .load(load), .load_pattern(load_pattern),
`endif
        .y(y1), .match_cnt(cnt1), .cnt_sat(sat1)
    );

    typedef struct {
        logic       y0;
        logic       y1;
        logic [7:0] c0;
        logic [1:0] c1;
        logic       s0;
        logic       s1;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nmis = 0;
    int   cyc  = 0;
    logic [7:0] m0 = '0;
    logic [1:0] m1 = '0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Expected counts come from the hand-written y expectations plus reset/clear rules.
    task automatic push_and_update(input logic rst, input logic clr, input logic ey0, input logic ey1);
        exp_t e;
        e.y0 = ey0 & rst;
        e.y1 = ey1 & rst;
        e.c0 = m0;
        e.c1 = m1;
        e.s0 = (m0 == 8'hFF);
        e.s1 = (m1 == 2'b11);
        q.push_back(e);
        if (!rst) begin
            m0 = '0;
            m1 = '0;
        end else if (clr) begin
            m0 = ey0 ? 8'd1 : 8'd0;
            m1 = ey1 ? 2'd1 : 2'd0;
        end else begin
            if (ey0 && m0 != 8'hFF) m0 = m0 + 8'd1;
            if (ey1 && m1 != 2'b11) m1 = m1 + 2'd1;
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic av, input logic clr,
                        input logic ey0, input logic ey1);
        @(negedge clk);
        reset_n = rst;
        enable  = en;
        a       = av;
        cnt_clr = clr;
`ifdef MEALY_PATTERN_LOAD_EN
        load    = 1'b0;
`endif
        push_and_update(rst, clr, ey0, ey1);
    endtask

    // Bits and expected-y masks are listed oldest first (MSB of the n-bit field).
    task automatic stream(input int n, input logic [31:0] bits, input logic [31:0] ey0,
                          input logic [31:0] ey1);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, 1'b1, bits[i], 1'b0, ey0[i], ey1[i]);
        end
    endtask

`ifdef MEALY_PATTERN_LOAD_EN
    task automatic step_load(input logic [3:0] pat);
        @(negedge clk);
        reset_n      = 1'b1;
        enable       = 1'b1;
        a            = 1'b1;
        cnt_clr      = 1'b0;
        load         = 1'b1;
        load_pattern = pat;
        push_and_update(1'b1, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("y_ovl",     {7'd0, y0},   {7'd0, e.y0});
                chk("y_novl",    {7'd0, y1},   {7'd0, e.y1});
                chk("cnt_ovl",   cnt0,         e.c0);
                chk("cnt_novl",  {6'd0, cnt1}, {6'd0, e.c1});
                chk("sat_ovl",   {7'd0, sat0}, {7'd0, e.s0});
                chk("sat_novl",  {7'd0, sat1}, {7'd0, e.s1});
            end
        end
    end

    initial begin : driver
        reset_n = 1'b0;
        enable  = 1'b0;
        a       = 1'b0;
        cnt_clr = 1'b0;
`ifdef MEALY_PATTERN_LOAD_EN
        load         = 1'b0;
        load_pattern = 4'b0000;
`endif
        repeat (2) @(negedge clk);

        // Reset state, then basic and overlapping matches
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        stream(7, 32'b1101101, 32'b0001001, 32'b0001000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Enable gap with toggling a
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // Reset mid-sequence: the reset edge would otherwise complete 1101
        stream(3, 32'b110, 32'b0, 32'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        stream(5, 32'b11101, 32'b00001, 32'b00001);

        // Clear alone, then five matches saturate the 2-bit counter
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        stream(20, 32'hDDDDD, 32'h11111, 32'h11111);

        // Clear coinciding with a hit
        stream(3, 32'b110, 32'b0, 32'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef MEALY_PATTERN_LOAD_EN
        step_load(4'b0110);
        stream(8, 32'b11010110, 32'b00000001, 32'b00000001);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #2;
        nvec++;
        if (q.size() != 0) begin
            nmis++;
            $display("FAIL drain: got %0d pending vectors expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
